// File: rtl/pipe_if_id_stage_if.sv
// pipe_if_id_stage_if
// Instruction-memory request/acknowledge bus between the fetch stage and
// instruction memory.
//   imem_req   : fetch stage -> memory, request pending
//   imem_addr  : fetch stage -> memory, request address (stable until ack)
//   imem_rdata : memory -> fetch stage, instruction word, valid with ack
//   imem_ack   : memory -> fetch stage, one-cycle completion of the request
// Modports: master = fetch stage, slave = instruction memory.

interface pipe_if_id_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ack
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ack
    );
endinterface

// File: rtl/pipe_if_id_stage.sv
// pipe_if_id_stage
// Fetch-side sequential stage of the 5-stage pipeline: PC register, the
// instruction-memory handshake and the IF/ID register feeding decode. A
// one-entry hold buffer absorbs decode stalls, and a DROP state discards
// data of a request that was flushed while still outstanding.
//
// Ports:
//   clock, reset  : rising-edge clock, synchronous active-high reset
//   npc           : next PC, taken only when the PC advances
//   wpcir         : 1 = decode accepts a new IF/ID value this cycle
//   flush         : discard fetched/in-flight instruction, go to redirect_pc
//   redirect_pc   : flush target
//   pc            : current fetch PC
//   imem          : instruction-memory bus (master modport)
//   dpc4/dinst/dvalid : IF/ID register contents
//   bubble_cnt/stall_cnt : performance counters
//
// Optional feature macro: PIPE_IF_PERF_EN. When defined, bubble_cnt counts
// clocks that load a bubble into IF/ID and stall_cnt counts clocks with
// wpcir=0 and flush=0. When undefined both outputs are tied to zero.

module pipe_if_id_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] npc,
    input  logic        wpcir,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc,
    pipe_if_id_stage_if.master imem,
    output logic [31:0] dpc4,
    output logic [31:0] dinst,
    output logic        dvalid,
    output logic [31:0] bubble_cnt,
    output logic [31:0] stall_cnt
);

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_HOLD = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    logic [1:0]  state, state_next;
    logic [31:0] pc_next;
    logic [31:0] buf_inst, buf_inst_next;
    logic [31:0] buf_pc4, buf_pc4_next;
    logic [31:0] drop_target, drop_target_next;
    logic [31:0] fetch_pc4;

    logic        ifid_load;
    logic [31:0] ifid_inst;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;

    assign fetch_pc4      = pc + 32'd4;
    assign imem.imem_req  = (state != S_HOLD);
    assign imem.imem_addr = pc;

    // Next-state decode. Flush takes priority over everything else; a flush
    // that arrives before the ack cannot retarget the request (the address
    // must stay stable), so the target is parked until the stale ack arrives.
    always_comb begin
        state_next       = state;
        pc_next          = pc;
        buf_inst_next    = buf_inst;
        buf_pc4_next     = buf_pc4;
        drop_target_next = drop_target;
        ifid_load        = 1'b0;
        ifid_inst        = NOP_INST;
        ifid_pc4         = dpc4;
        ifid_valid       = 1'b0;
        case (state)
            S_REQ: begin
                if (flush) begin
                    ifid_load = 1'b1;
                    if (imem.imem_ack) begin
                        pc_next = redirect_pc;
                    end else begin
                        drop_target_next = redirect_pc;
                        state_next       = S_DROP;
                    end
                end else if (imem.imem_ack) begin
                    if (wpcir) begin
                        ifid_load  = 1'b1;
                        ifid_inst  = imem.imem_rdata;
                        ifid_pc4   = fetch_pc4;
                        ifid_valid = 1'b1;
                        pc_next    = npc;
                    end else begin
                        buf_inst_next = imem.imem_rdata;
                        buf_pc4_next  = fetch_pc4;
                        state_next    = S_HOLD;
                    end
                end else if (wpcir) begin
                    ifid_load = 1'b1;
                end
            end
            S_HOLD: begin
                if (flush) begin
                    ifid_load  = 1'b1;
                    pc_next    = redirect_pc;
                    state_next = S_REQ;
                end else if (wpcir) begin
                    ifid_load  = 1'b1;
                    ifid_inst  = buf_inst;
                    ifid_pc4   = buf_pc4;
                    ifid_valid = 1'b1;
                    pc_next    = npc;
                    state_next = S_REQ;
                end
            end
            S_DROP: begin
                if (flush || wpcir) begin
                    ifid_load = 1'b1;
                end
                if (flush) begin
                    drop_target_next = redirect_pc;
                end
                // A flush coinciding with the stale ack is the newest target.
                if (imem.imem_ack) begin
                    pc_next    = flush ? redirect_pc : drop_target;
                    state_next = S_REQ;
                end
            end
            default: begin
                state_next = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_REQ;
            pc          <= RESET_PC;
            buf_inst    <= '0;
            buf_pc4     <= '0;
            drop_target <= '0;
            dinst       <= NOP_INST;
            dpc4        <= '0;
            dvalid      <= 1'b0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            buf_inst    <= buf_inst_next;
            buf_pc4     <= buf_pc4_next;
            drop_target <= drop_target_next;
            if (ifid_load) begin
                dinst  <= ifid_inst;
                dpc4   <= ifid_pc4;
                dvalid <= ifid_valid;
            end
        end
    end

`ifdef PIPE_IF_PERF_EN
    logic bubble_load;
    assign bubble_load = ifid_load & ~ifid_valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            bubble_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            if (bubble_load) begin
                bubble_cnt <= bubble_cnt + 32'd1;
            end
            if (!wpcir && !flush) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`else
    assign bubble_cnt = '0;
    assign stall_cnt  = '0;
`endif

endmodule

// File: doc/pipe_if_id_stage.md
Name: pipe_if_id_stage

Overview:
- Fetch-side sequential stage of the 5-stage pipelined CPU.
- Contents:
  - the PC register, loaded from the next-PC mux output;
  - the instruction-memory request/acknowledge handshake;
  - the IF/ID pipeline register that feeds the decode stage.
- Absorbs variable-latency instruction memory, ID stalls (wpcir) and control-flow flushes, with a one-entry hold buffer.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0000, instruction word inserted into IF/ID for bubbles and flushes.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- npc  input  32  next PC from the next-PC mux; sampled only when the PC advances.
- wpcir  input  1  1 = ID accepts a new IF/ID value this cycle; 0 = ID stalled, IF/ID and PC hold.
- flush  input  1  1 = discard the fetched and in-flight instruction, redirect to redirect_pc.
- redirect_pc  input  32  flush target.
- pc  output  32  current fetch PC (to the pc+4 adder, next-PC mux and imem).
- imem_req  output  1  instruction-memory request.
- imem_addr  output  32  request address; always equals pc.
- imem_rdata  input  32  instruction word; valid when imem_ack=1.
- imem_ack  input  1  one-cycle completion of the outstanding request.
- dpc4  output  32  IF/ID register: PC+4 of the held instruction.
- dinst  output  32  IF/ID register: instruction.
- dvalid  output  1  IF/ID register: 1 = real instruction, 0 = bubble.
- bubble_cnt  output  32  bubble counter (Optional Feature).
- stall_cnt  output  32  stall counter (Optional Feature).

Behaviour:
- Reset (sync, reset=1 at clock edge):
  - pc = RESET_PC; state = REQ; dinst = NOP_INST; dpc4 = 0; dvalid = 0.
  - hold buffer cleared; counters = 0.
  - Reset overrides every other input, including mid-transaction; an imem_ack arriving in the reset cycle is ignored.
- imem protocol:
  - imem_req is held high until imem_ack.
  - imem_addr must not change while imem_req=1 and no ack has been received.
  - imem_ack is never asserted while imem_req=0 (bench enforces).
- States:
  - REQ: imem_req=1.
  - HOLD: imem_req=0; fetched word is in the buffer, waiting for wpcir.
  - DROP: imem_req=1; flushed request is still outstanding and its data will be discarded; the pending target is stored in an internal register.
- REQ, priority flush > ack/wpcir:
  - flush & ack: IF/ID := bubble (NOP_INST, dvalid=0); pc := redirect_pc; stay REQ.
  - flush & !ack: IF/ID := bubble; store redirect_pc; go DROP; pc unchanged, so imem_addr stays stable.
  - ack & wpcir: dinst := imem_rdata; dpc4 := pc+4 (mod 2^32); dvalid := 1; pc := npc; stay REQ. Zero-bubble fetch when memory is single-cycle.
  - ack & !wpcir: buffer := {imem_rdata, pc+4}; go HOLD; pc and IF/ID hold.
  - !ack & wpcir: IF/ID := bubble; pc hold.
  - !ack & !wpcir: everything holds.
- HOLD:
  - flush: IF/ID := bubble; pc := redirect_pc; buffer discarded; go REQ.
  - wpcir: IF/ID := buffer with dvalid=1; pc := npc; go REQ.
  - otherwise: hold.
- DROP:
  - ack: discard imem_rdata; pc := stored target; go REQ.
  - flush again: stored target := new redirect_pc (last flush wins); stay DROP.
  - IF/ID: becomes a bubble when wpcir=1 or flush=1, otherwise holds.
- Flush always forces a bubble into IF/ID, regardless of wpcir.
- Latency: single-cycle imem gives one instruction per cycle. An N-cycle ack gives N-1 bubbles per instruction while wpcir=1.

Optional Feature:
- Macro: PIPE_IF_PERF_EN.
- When defined:
  - bubble_cnt increments on every clock where IF/ID is loaded with a bubble;
  - stall_cnt increments on every clock with wpcir=0 and flush=0;
  - both counters wrap at 2^32 and clear on reset.
- When undefined: both ports are driven constant 0 and no counter flops exist.

Test Plan:
- Reset, then single-cycle imem (ack every request), wpcir=1, npc=pc+4 -> pc sequence 0,4,8,C; dinst matches memory words one cycle after each address; dvalid=1 from the 2nd cycle on; dpc4 = 4,8,C.
- 3-cycle imem latency, wpcir=1 -> two cycles dvalid=0 (dinst=NOP) between valid instructions; imem_addr stable across each wait; with PIPE_IF_PERF_EN, bubble_cnt=2 per instruction.
- Ack at pc=0x10 while wpcir=0 for 3 cycles -> state HOLD, imem_req=0, pc stays 0x10; on wpcir=1, dinst = word at 0x10 with dpc4=0x14, and pc=npc the next cycle; stall_cnt=3.
- flush with redirect_pc=0x200 while a request to 0x40 is outstanding -> dvalid=0 next cycle; imem_addr stays 0x40 until ack; the 0x40 data never appears in dinst; the next request is to 0x200.
- Two flushes (0x200 then 0x300) during DROP -> the first post-DROP request goes to 0x300.
- reset asserted in HOLD and during an outstanding request -> next cycle pc=RESET_PC, dvalid=0, counters=0, state REQ; a coincident ack is ignored.
